// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
//   CLK_HZ     : board clock frequency
//   DEF_CNT_W  : default counter / half-period width
//   DEF_HALF   : default half-period loaded at reset (~277.18 Hz output)
//   half_for_hz: half-period register value that yields a given output frequency
package clk_div_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned DEF_CNT_W = 26;
  localparam int unsigned DEF_HALF  = 90194;

  // Output period is 2*(half+1) clocks, so half = CLK_HZ/(2*hz) - 1.
  function automatic int unsigned half_for_hz(input int unsigned hz);
    return CLK_HZ / (2 * hz) - 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: 50 %-duty square wave plus a one-cycle tick on each rising toggle.
// A newly loaded half-period is held in a shadow register and only takes effect at the
// terminal count (or immediately while disabled), so the output never shows a runt pulse.
//   clk_50MHz : clock
//   reset     : synchronous active-high reset
//   en        : run enable; low forces the channel to ctr=0, clk_out=0
//   load      : accept load_val into the shadow register this cycle
//   load_val  : new half-period
//   clk_out   : divided square wave (registered)
//   tick      : one-cycle strobe following each 0->1 edge of clk_out (registered)
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned DEFAULT_HALF = DEF_HALF
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] ctr_q, ctr_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             terminal;
  logic             apply;

  assign terminal = (ctr_q == half_q);
  // Safe points to swap in a new half-period: end of a half-period, or any time while idle.
  assign apply    = en ? terminal : 1'b1;

  always_comb begin
    ctr_d     = ctr_q;
    half_d    = half_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;

    if (en) begin
      if (terminal) begin
        ctr_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = ~clk_out_q;
      end else begin
        ctr_d = ctr_q + CNT_W'(1);
      end
    end else begin
      ctr_d     = '0;
      clk_out_d = 1'b0;
    end

    if (apply && pending_q) begin
      half_d    = shadow_q;
      pending_d = 1'b0;
    end

    // Evaluated after the apply step: a load coinciding with the swap lets the old shadow
    // go live and leaves the new value pending for the next safe point.
    if (load) begin
      shadow_d  = load_val;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      ctr_q     <= '0;
      half_q    <= CNT_W'(DEFAULT_HALF);
      shadow_q  <= CNT_W'(DEFAULT_HALF);
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      half_q    <= half_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel run-time programmable clock divider.
// Holds the valid/ready config port and decodes the target channel; the dividing itself
// lives in clk_div_ch.
//   clk_50MHz : board clock
//   reset     : synchronous active-high reset
//   en        : per-channel run enable
//   cfg_valid : config request
//   cfg_ready : config port can accept (busy for one cycle after each transfer)
//   cfg_ch    : target channel; out-of-range indices complete the handshake with no effect
//   cfg_half  : new half-period value
//   clk_out   : per-channel divided square waves
//   tick      : per-channel one-cycle pulse after each clk_out rising edge
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned  NUM_CH       = 4,
  parameter int unsigned  CNT_W        = DEF_CNT_W,
  parameter int unsigned  DEFAULT_HALF = DEF_HALF,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic              cfg_ready_q, cfg_ready_d;
  logic              xfer;
  logic [NUM_CH-1:0] load;

  assign xfer = cfg_valid & cfg_ready_q;

  // One busy cycle after every accepted transfer.
  always_comb begin
    cfg_ready_d = ~xfer;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      cfg_ready_q <= 1'b1;
    end else begin
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign cfg_ready = cfg_ready_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = xfer && (cfg_ch == CH_W'(i));

    clk_div_ch #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_50MHz (clk_50MHz),
      .reset     (reset),
      .en        (en[i]),
      .load      (load[i]),
      .load_val  (cfg_half),
      .clk_out   (clk_out[i]),
      .tick      (tick[i])
    );
  end

endmodule
